// File: rtl/core_if.sv
// core_if: instruction fetch stage.
// Holds the PC and issues single-word reads on the instruction bus. Each
// fetched word is handed to decode as a registered pc/instr pair. A one-entry
// skid buffer absorbs the word that lands while decode is halted. Redirects
// are served by dropping any in-flight read.
module core_if #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0008
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_halt,
   input  logic        branch,
   input  logic [31:0] branch_target,
   input  logic        exc,
   output logic        ibus_req,
   output logic [31:0] ibus_addr,
   input  logic        ibus_ack,
   input  logic [31:0] ibus_data,
   input  logic        ibus_err,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_valid,
   output logic        if_err
);

   localparam logic [5:0]  OPCODE_NOP = 6'h04;
   localparam logic [31:0] NOP_RESET  = {OPCODE_NOP, 26'd0};
   localparam logic [31:0] BUBBLE     = {OPCODE_NOP, 26'd2};

   typedef enum logic [1:0] {S_RST, S_FETCH, S_DISCARD, S_WAITH} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic        err;
   } fetch_word_t;

   state_t      state, state_nxt;
   logic        rst_seen;
   logic [31:0] pc, pc_nxt;
   logic [31:0] pend, pend_nxt;
   fetch_word_t out_q, out_nxt;
   logic        out_vld, out_vld_nxt;
   fetch_word_t skid_q, skid_nxt;
   logic        skid_full, skid_full_nxt;
   fetch_word_t bus_word;
   logic        redirect;
   logic [31:0] redir_tgt;
   logic        unused_tgt_lsb;

   // Exception outranks branch; both targets are word aligned.
   assign redirect       = exc | branch;
   assign redir_tgt      = exc ? {EXC_VECTOR[31:2], 2'b00} : {branch_target[31:2], 2'b00};
   assign unused_tgt_lsb = ^branch_target[1:0];
   assign bus_word       = '{pc: pc, data: ibus_data, err: ibus_err};

   // State register; RST is held until one full clock has passed after release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_RST;
         rst_seen <= 1'b0;
      end else begin
         state    <= state_nxt;
         rst_seen <= 1'b1;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_RST:     if (rst_seen) state_nxt = S_FETCH;
         S_FETCH: begin
            if (redirect)                state_nxt = ibus_ack ? S_FETCH : S_DISCARD;
            else if (ibus_ack && if_halt) state_nxt = S_WAITH;
         end
         S_DISCARD: if (ibus_ack) state_nxt = S_FETCH;
         S_WAITH:   if (redirect || !if_halt) state_nxt = S_FETCH;
         default:   state_nxt = S_RST;
      endcase
   end

   // Outputs come straight from registers; the request depends on state only.
   always_comb begin
      ibus_req  = (state == S_FETCH) || (state == S_DISCARD);
      ibus_addr = pc;
      if_pc     = out_q.pc;
      if_instr  = out_q.data;
      if_err    = out_q.err;
      if_valid  = out_vld;
   end

   // Datapath next values: pc, pending target, skid and decode pair.
   always_comb begin
      pc_nxt        = pc;
      pend_nxt      = pend;
      out_nxt       = out_q;
      out_vld_nxt   = out_vld;
      skid_nxt      = skid_q;
      skid_full_nxt = skid_full;
      // Decode is free and nothing arrives unless overridden below: bubble.
      if (!if_halt) begin
         out_nxt.data = BUBBLE;
         out_nxt.err  = 1'b0;
         out_vld_nxt  = 1'b0;
      end
      if (redirect) begin
         out_nxt.data  = BUBBLE;
         out_nxt.err   = 1'b0;
         out_vld_nxt   = 1'b0;
         skid_full_nxt = 1'b0;
         // An unacked read must stay on the bus; remember where to go after it.
         if (((state == S_FETCH) || (state == S_DISCARD)) && !ibus_ack)
            pend_nxt = redir_tgt;
         else
            pc_nxt = redir_tgt;
      end else begin
         case (state)
            S_FETCH: begin
               if (ibus_ack) begin
                  pc_nxt = pc + 32'd4;
                  if (if_halt) begin
                     skid_nxt      = bus_word;
                     skid_full_nxt = 1'b1;
                  end else begin
                     out_nxt     = bus_word;
                     out_vld_nxt = 1'b1;
                  end
               end
            end
            S_DISCARD: if (ibus_ack) pc_nxt = pend;
            S_WAITH: begin
               if (!if_halt) begin
                  out_nxt       = skid_q;
                  out_vld_nxt   = skid_full;
                  skid_full_nxt = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc        <= RESET_PC;
         pend      <= RESET_PC;
         out_q     <= '{pc: 32'd0, data: NOP_RESET, err: 1'b0};
         out_vld   <= 1'b0;
         skid_q    <= '0;
         skid_full <= 1'b0;
      end else begin
         pc        <= pc_nxt;
         pend      <= pend_nxt;
         out_q     <= out_nxt;
         out_vld   <= out_vld_nxt;
         skid_q    <= skid_nxt;
         skid_full <= skid_full_nxt;
      end
   end

endmodule

// File: tb/tb_core_if.sv
// Directed bench for core_if: a wait-state-programmable bus that returns
// the address as data, plus hand-computed expected outputs per cycle.
module tb_core_if;

   localparam logic [31:0] NOP_RESET = 32'h1000_0000;
   localparam logic [31:0] BUBBLE    = 32'h1000_0002;

   logic        clk, rst, if_halt, branch, exc;
   logic [31:0] branch_target;
   logic        ibus_req, ibus_ack, ibus_err;
   logic [31:0] ibus_addr, ibus_data;
   logic [31:0] if_pc, if_instr;
   logic        if_valid, if_err;

   int          n_chk = 0;
   int          n_err = 0;

   // Bus model
   logic [1:0]  wait_cfg;
   logic [31:0] err_addr;
   int          wcnt = 0;
   assign ibus_ack  = ibus_req && (wcnt >= int'(wait_cfg));
   assign ibus_data = ibus_addr;
   assign ibus_err  = ibus_ack && (ibus_addr == err_addr);

   always @(posedge clk) begin
      if (ibus_req && !ibus_ack) wcnt <= wcnt + 1;
      else                       wcnt <= 0;
   end

   // Request must stay put with the same address until acked.
   logic        p_req = 1'b0;
   logic        p_ack = 1'b0;
   logic [31:0] p_addr = '0;
   int          bus_viol = 0;
   always @(negedge clk) begin
      if (rst && p_req && !p_ack && (!ibus_req || ibus_addr != p_addr))
         bus_viol <= bus_viol + 1;
      p_req  <= ibus_req;
      p_ack  <= ibus_ack;
      p_addr <= ibus_addr;
   end

   core_if #(.RESET_PC(32'h0), .EXC_VECTOR(32'h8)) dut (
      .clk(clk), .rst(rst), .if_halt(if_halt), .branch(branch),
      .branch_target(branch_target), .exc(exc),
      .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ack(ibus_ack),
      .ibus_data(ibus_data), .ibus_err(ibus_err),
      .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .if_err(if_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; if_halt = 1'b0; branch = 1'b0; exc = 1'b0;
      branch_target = '0; wait_cfg = 2'd0; err_addr = 32'h10;
      repeat (2) tick();
      chk("rst_req",   ibus_req,  0);
      chk("rst_addr",  ibus_addr, 32'h0);
      chk("rst_pc",    if_pc,     32'h0);
      chk("rst_instr", if_instr,  NOP_RESET);
      chk("rst_valid", if_valid,  0);
      chk("rst_err",   if_err,    0);

      // Release: one idle cycle then streaming at one word per cycle.
      rst = 1'b1;
      tick(); chk("rst_cyc_req", ibus_req, 0);
      tick(); chk("first_req", ibus_req, 1); chk("first_addr", ibus_addr, 32'h0);
      tick(); chk("o0_pc", if_pc, 32'h0); chk("o0_instr", if_instr, 32'h0);
              chk("o0_valid", if_valid, 1); chk("a4", ibus_addr, 32'h4);
      tick(); chk("o4_pc", if_pc, 32'h4); chk("o4_instr", if_instr, 32'h4); chk("a8", ibus_addr, 32'h8);
      tick(); chk("o8_pc", if_pc, 32'h8); chk("o8_instr", if_instr, 32'h8); chk("aC", ibus_addr, 32'hC);

      // Halt three cycles: word 0xC goes to skid, outputs freeze.
      if_halt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("halt_req", ibus_req, 0);
         chk("halt_pc", if_pc, 32'h8);
         chk("halt_valid", if_valid, 1);
      end
      if_halt = 1'b0;
      tick(); chk("skid_pc", if_pc, 32'hC); chk("skid_instr", if_instr, 32'hC);
              chk("skid_valid", if_valid, 1); chk("skid_addr", ibus_addr, 32'h10);

      // 0x10 faults on the bus.
      tick(); chk("err_pc", if_pc, 32'h10); chk("err_flag", if_err, 1);
              chk("err_valid", if_valid, 1); chk("err_next", ibus_addr, 32'h14);
      tick(); chk("after_err_pc", if_pc, 32'h14); chk("after_err_flag", if_err, 0);
      tick(); tick();
      chk("a20", ibus_addr, 32'h20);

      // Branch to 0x103 during a two-wait-state read of 0x20.
      wait_cfg = 2'd2;
      tick(); chk("wait_valid", if_valid, 0); chk("wait_addr", ibus_addr, 32'h20);
      branch = 1'b1; branch_target = 32'h103;
      tick(); branch = 1'b0;
      chk("br_instr", if_instr, BUBBLE); chk("br_valid", if_valid, 0);
      chk("br_hold_req", ibus_req, 1); chk("br_hold_addr", ibus_addr, 32'h20);
      tick(); chk("br_tgt", ibus_addr, 32'h100); chk("br_drop_valid", if_valid, 0);
      wait_cfg = 2'd0;
      tick(); chk("br_o_pc", if_pc, 32'h100); chk("br_o_instr", if_instr, 32'h100);
              chk("br_o_valid", if_valid, 1); chk("br_a104", ibus_addr, 32'h104);

      // exc and branch together: exception vector wins.
      exc = 1'b1; branch = 1'b1; branch_target = 32'h40;
      tick(); exc = 1'b0; branch = 1'b0;
      chk("exc_addr", ibus_addr, 32'h8); chk("exc_valid", if_valid, 0);
      chk("exc_instr", if_instr, BUBBLE); chk("exc_err", if_err, 0);
      tick(); chk("exc_o_pc", if_pc, 32'h8); chk("exc_o_valid", if_valid, 1);

      // Reset in the middle of an outstanding read of 0x30.
      for (int i = 0; i < 20 && ibus_addr != 32'h30; i++) tick();
      chk("reach_30", ibus_addr, 32'h30);
      wait_cfg = 2'd3;
      tick(); chk("pend_req", ibus_req, 1); chk("pend_addr", ibus_addr, 32'h30);
      rst = 1'b0;
      #1;
      chk("mid_rst_req", ibus_req, 0); chk("mid_rst_addr", ibus_addr, 32'h0);
      chk("mid_rst_valid", if_valid, 0); chk("mid_rst_instr", if_instr, NOP_RESET);
      wait_cfg = 2'd0;
      tick(); rst = 1'b1;
      tick(); chk("re_rst_cyc", ibus_req, 0);
      tick(); chk("re_req", ibus_req, 1); chk("re_addr", ibus_addr, 32'h0);
      tick(); chk("re_o_pc", if_pc, 32'h0); chk("re_o_valid", if_valid, 1);

      chk("bus_hold", bus_viol, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
